jtkcpu_stkseq: RTL and testbench
================================

Name: jtkcpu_stkseq

Overview:
- Push/pull sequencer for PSHS/PSHU/PULS/PULU and interrupt stacking.
- Walks an 8-bit register mask one byte per cen.
- Drives the memory controller's stack inputs (psh_addr, psh_dec, stack_busy, psh_mux).
- On pulls, reassembles bytes from the fetched data bus and writes them back to the register file.
- Sits directly upstream of the memory controller; the control unit starts it.

Parameters:
- none

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cen  in  1  CPU clock enable; one stack byte per cen
- psh_go  in  1  start push; sampled on cen while idle
- pul_go  in  1  start pull; sampled on cen while idle
- use_u  in  1  0: stack on S, 1: stack on U
- mask  in  8  b0 CC, b1 A, b2 B, b3 DP, b4 X, b5 Y, b6 other SP (U if use_u=0, else S), b7 PC
- cc, a, b, dp  in  8 each  register values to push
- x, y, u, s, pc  in  16 each  register values to push
- din  in  8  byte returned by memory controller (valid one cen after address issued)
- psh_addr  out  16  current stack pointer value presented to memory controller
- psh_dec  out  1  push byte this cen (controller writes psh_mux at psh_addr-1)
- stack_busy  out  1  pull read this cen (controller reads psh_addr)
- psh_mux  out  8  byte to be pushed
- busy  out  1  sequence in progress
- sp_we  out  1  one-cen strobe: write sp_nxt into selected SP
- sp_nxt  out  16  updated stack pointer
- pul_we  out  1  one-cen strobe: write pul_data into register pul_sel
- pul_sel  out  3  0 CC, 1 A, 2 B, 3 DP, 4 X, 5 Y, 6 other SP, 7 PC
- pul_data  out  16  pulled value; 8-bit registers in [7:0], [15:8]=0
- wrap  out  1  stack pointer wrapped past 0x0000/0xFFFF (see Optional Feature)

Behaviour:
- Reset: all outputs 0; state IDLE; latched mask/sp cleared.
- All state changes only on cen.
- Reset mid-sequence aborts immediately; no further strobes.
- States: IDLE, PUSH, PULL, DRAIN.
- IDLE:
  - psh_go → latch mask, sp = (use_u ? u : s), go PUSH.
  - pul_go (without psh_go) → go PULL.
  - Both high: push wins.
  - mask=0: stays IDLE, busy stays 0, no strobes.
  - Go pulses while busy=1 are ignored.
- busy=1 from the cen after go until the cen that leaves PUSH/DRAIN.
- PUSH:
  - Byte order: PC lo, PC hi, SP lo, SP hi, Y lo, Y hi, X lo, X hi, DP, B, A, CC; masked-out entries skipped with zero cycles.
  - Each cen: psh_dec=1, psh_addr=sp, psh_mux=byte; then sp=sp-1.
  - After last byte: sp_we=1, sp_nxt=sp, return IDLE.
- PULL:
  - Order: CC, A, B, DP, X hi, X lo, Y hi, Y lo, SP hi, SP lo, PC hi, PC lo.
  - Each cen: stack_busy=1, psh_addr=sp; then sp=sp+1.
  - Byte for address issued at cen n is captured from din at cen n+1.
  - After last address issued → DRAIN, capturing the final byte.
  - Then pul_we for the last register, sp_we with final sp, return IDLE.
- pul_we fires the cen after a register's final byte is captured; at most one pul_we per cen.
- 16-bit registers: hi byte held until lo byte arrives.
- Pull of PC: pul_we with pul_sel=7; the control unit handles the refetch.
- Arithmetic: sp modulo 2^16; 0x0000-1 = 0xFFFF and 0xFFFF+1 = 0x0000 both wrap silently.
- Mask bit 6 with use_u=0 pushes/pulls U; with use_u=1 pushes/pulls S. The active SP itself is never in the list.

Optional Feature:
- Macro JTKCPU_STKSEQ_WRAP_EN.
- Defined: wrap is set on the cen where sp steps 0x0000→0xFFFF (push) or 0xFFFF→0x0000 (pull); sticky until the next accepted go.
- Undefined: wrap tied to 0; no extra flops.

Test Plan:
- Push: S=0x1000, mask=0x81, PC=0x1234, CC=0x5A, psh_go →
  - psh_addr/psh_mux sequence 0x1000/0x34, 0x0FFF/0x12, 0x0FFE/0x5A;
  - sp_we with sp_nxt=0x0FFD; busy high 3 cens.
- Pull: S=0x0FFD, mask=0x81, din returns 0x5A,0x12,0x34 →
  - pul_we CC=0x005A, then PC=0x1234;
  - sp_nxt=0x1000.
- Full mask 0xFF push on U=0x2000, use_u=1 → 12 psh_dec cycles, S pushed as other SP, sp_nxt=0x1FF4; mask=0x00 → busy never rises, no strobes.
- psh_go and pul_go high together on S=0x0001, mask=0x02 → push only, A written via psh_addr 0x0001, sp_nxt=0x0000.
  - Then mask=0x06 push from 0x0000 → sp_nxt=0xFFFE; wrap=1 only with JTKCPU_STKSEQ_WRAP_EN.
- Reset: rst_n low during 3rd byte of 0xFF push → all outputs 0 at once; no sp_we.
  - After release, a new psh_go on the next cen starts cleanly.
- psh_go asserted while busy → ignored; cen held low for 5 clocks mid-pull → outputs frozen, sequence resumes unchanged.

Source files
------------

// File: rtl/jtkcpu_stkseq.sv
// Push/pull stack sequencer: walks a register mask one byte per cen and drives the memory controller's stack port.
// Optional JTKCPU_STKSEQ_WRAP_EN: sticky flag when the stack pointer wraps through 0x0000/0xFFFF.
module jtkcpu_stkseq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cen,
   input  logic        psh_go,
   input  logic        pul_go,
   input  logic        use_u,
   input  logic [7:0]  mask,
   input  logic [7:0]  cc,
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   input  logic [7:0]  dp,
   input  logic [15:0] x,
   input  logic [15:0] y,
   input  logic [15:0] u,
   input  logic [15:0] s,
   input  logic [15:0] pc,
   input  logic [7:0]  din,
   output logic [15:0] psh_addr,
   output logic        psh_dec,
   output logic        stack_busy,
   output logic [7:0]  psh_mux,
   output logic        busy,
   output logic        sp_we,
   output logic [15:0] sp_nxt,
   output logic        pul_we,
   output logic [2:0]  pul_sel,
   output logic [15:0] pul_data,
   output logic        wrap
);

   typedef enum logic [1:0] {IDLE, PUSH, PULL, DRAIN} state_t;

   state_t      state_reg, state_next;
   logic [11:0] pend_reg, pend_clr, push_slots, pull_slots;
   logic [3:0]  slot, capt_slot_reg;
   logic [15:0] sp_reg, other_sp, sp_nxt_reg, pul_data_reg;
   logic        use_u_reg, capt_reg, sp_we_reg, pul_we_reg;
   logic [7:0]  hi_reg, byte_mux;
   logic [2:0]  pul_sel_reg, capt_sel;
   logic        capt_hi, go_push, go_pull, last;

   // Each mask bit expands to one or two byte slots; slot 0 is handled first.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_slot8
         assign push_slots[11-gi] = mask[gi];
         assign pull_slots[gi]    = mask[gi];
      end
      for (gi = 0; gi < 4; gi++) begin : g_slot16
         assign push_slots[6-2*gi] = mask[4+gi];
         assign push_slots[7-2*gi] = mask[4+gi];
         assign pull_slots[4+2*gi] = mask[4+gi];
         assign pull_slots[5+2*gi] = mask[4+gi];
      end
   endgenerate

   always_comb begin
      slot = 4'd0;
      for (int i = 11; i >= 0; i--) begin
         if (pend_reg[i]) slot = 4'(i);
      end
   end

   assign pend_clr = pend_reg & ~(12'd1 << slot);
   assign last     = (pend_clr == 12'd0);
   assign go_push  = (state_reg == IDLE) && psh_go && (mask != 8'd0);
   assign go_pull  = (state_reg == IDLE) && !psh_go && pul_go && (mask != 8'd0);
   assign other_sp = use_u_reg ? s : u;

   always_comb begin
      case (slot)
         4'd0:    byte_mux = pc[7:0];
         4'd1:    byte_mux = pc[15:8];
         4'd2:    byte_mux = other_sp[7:0];
         4'd3:    byte_mux = other_sp[15:8];
         4'd4:    byte_mux = y[7:0];
         4'd5:    byte_mux = y[15:8];
         4'd6:    byte_mux = x[7:0];
         4'd7:    byte_mux = x[15:8];
         4'd8:    byte_mux = dp;
         4'd9:    byte_mux = b;
         4'd10:   byte_mux = a;
         default: byte_mux = cc;
      endcase
   end

   // Pull slots 4..11 pair up as hi/lo bytes of X, Y, other SP, PC.
   assign capt_sel = (capt_slot_reg < 4'd4) ? capt_slot_reg[2:0] : capt_slot_reg[3:1] + 3'd2;
   assign capt_hi  = (capt_slot_reg >= 4'd4) && !capt_slot_reg[0];

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (go_push) state_next = PUSH; else if (go_pull) state_next = PULL;
         PUSH:    if (last) state_next = IDLE;
         PULL:    if (last) state_next = DRAIN;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   state_reg <= IDLE;
      else if (cen) state_reg <= state_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_reg      <= 12'd0;
         sp_reg        <= 16'd0;
         use_u_reg     <= 1'b0;
         capt_reg      <= 1'b0;
         capt_slot_reg <= 4'd0;
         hi_reg        <= 8'd0;
         sp_we_reg     <= 1'b0;
         sp_nxt_reg    <= 16'd0;
         pul_we_reg    <= 1'b0;
         pul_sel_reg   <= 3'd0;
         pul_data_reg  <= 16'd0;
      end else if (cen) begin
         sp_we_reg  <= 1'b0;
         pul_we_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               capt_reg <= 1'b0;
               if (go_push || go_pull) begin
                  pend_reg  <= go_push ? push_slots : pull_slots;
                  sp_reg    <= use_u ? u : s;
                  use_u_reg <= use_u;
               end
            end
            PUSH: begin
               pend_reg <= pend_clr;
               sp_reg   <= sp_reg - 16'd1;
               if (last) begin
                  sp_we_reg  <= 1'b1;
                  sp_nxt_reg <= sp_reg - 16'd1;
               end
            end
            PULL: begin
               pend_reg      <= pend_clr;
               sp_reg        <= sp_reg + 16'd1;
               capt_reg      <= 1'b1;
               capt_slot_reg <= slot;
            end
            default: begin
               capt_reg   <= 1'b0;
               sp_we_reg  <= 1'b1;
               sp_nxt_reg <= sp_reg;
            end
         endcase
         // din answers the address issued on the previous cen
         if (capt_reg) begin
            if (capt_hi) begin
               hi_reg <= din;
            end else begin
               pul_we_reg   <= 1'b1;
               pul_sel_reg  <= capt_sel;
               pul_data_reg <= (capt_slot_reg >= 4'd4) ? {hi_reg, din} : {8'h00, din};
            end
         end
      end
   end

`ifdef JTKCPU_STKSEQ_WRAP_EN
   logic wrap_reg;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrap_reg <= 1'b0;
      end else if (cen) begin
         if (go_push || go_pull)
            wrap_reg <= 1'b0;
         else if ((state_reg == PUSH && sp_reg == 16'h0000) ||
                  (state_reg == PULL && sp_reg == 16'hFFFF))
            wrap_reg <= 1'b1;
      end
   end
   assign wrap = wrap_reg;
`else
   assign wrap = 1'b0;
`endif

   assign psh_addr   = sp_reg;
   assign psh_dec    = (state_reg == PUSH);
   assign stack_busy = (state_reg == PULL);
   assign psh_mux    = (state_reg == PUSH) ? byte_mux : 8'd0;
   assign busy       = (state_reg != IDLE);
   assign sp_we      = sp_we_reg;
   assign sp_nxt     = sp_nxt_reg;
   assign pul_we     = pul_we_reg;
   assign pul_sel    = pul_sel_reg;
   assign pul_data   = pul_data_reg;

endmodule

// File: tb/tb_jtkcpu_stkseq.sv
// Directed bench for jtkcpu_stkseq with a byte-wide memory controller model behind the stack port.
module tb_jtkcpu_stkseq;

   logic        clk = 1'b0, rst_n = 1'b0, cen = 1'b1;
   logic        psh_go = 1'b0, pul_go = 1'b0, use_u = 1'b0;
   logic [7:0]  mask = 8'd0, cc = 8'd0, a = 8'd0, b = 8'd0, dp = 8'd0, din = 8'd0;
   logic [15:0] x = 16'd0, y = 16'd0, u = 16'd0, s = 16'd0, pc = 16'd0;
   logic [15:0] psh_addr, sp_nxt, pul_data;
   logic        psh_dec, stack_busy, busy, sp_we, pul_we, wrap;
   logic [7:0]  psh_mux;
   logic [2:0]  pul_sel;

   logic [7:0]  mem [0:65535];
   int          n_cmp = 0, n_err = 0;

`ifdef JTKCPU_STKSEQ_WRAP_EN
   localparam logic [15:0] EXP_WRAP = 16'd1;
`else
   localparam logic [15:0] EXP_WRAP = 16'd0;
`endif

   logic [7:0]  fb [12] = '{8'h34, 8'h12, 8'hEF, 8'hBE, 8'h66, 8'h55,
                            8'h88, 8'h77, 8'h99, 8'hBB, 8'hAA, 8'h5A};
   logic [15:0] pd [8]  = '{16'h005A, 16'h00AA, 16'h00BB, 16'h0099,
                            16'h7788, 16'h5566, 16'hBEEF, 16'h1234};

   jtkcpu_stkseq dut (
      .clk(clk), .rst_n(rst_n), .cen(cen), .psh_go(psh_go), .pul_go(pul_go),
      .use_u(use_u), .mask(mask), .cc(cc), .a(a), .b(b), .dp(dp),
      .x(x), .y(y), .u(u), .s(s), .pc(pc), .din(din),
      .psh_addr(psh_addr), .psh_dec(psh_dec), .stack_busy(stack_busy),
      .psh_mux(psh_mux), .busy(busy), .sp_we(sp_we), .sp_nxt(sp_nxt),
      .pul_we(pul_we), .pul_sel(pul_sel), .pul_data(pul_data), .wrap(wrap)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
      end
   endtask

   // One clock; the memory model answers reads and performs writes issued before the edge.
   task automatic tick();
      logic rd, wr, en;
      logic [15:0] ad;
      logic [7:0]  wd;
      rd = stack_busy; wr = psh_dec; ad = psh_addr; wd = psh_mux; en = cen & rst_n;
      @(posedge clk);
      #1;
      if (en) begin
         if (rd) din = mem[ad];
         if (wr) mem[ad - 16'd1] = wd;
      end
   endtask

   initial begin
      int k;
      logic done;
      for (int i = 0; i < 65536; i++) mem[i] = 8'd0;

      // reset state
      tick(); tick();
      check("rst_busy", 16'(busy), 16'd0);
      check("rst_dec", 16'(psh_dec), 16'd0);
      check("rst_sbusy", 16'(stack_busy), 16'd0);
      check("rst_addr", psh_addr, 16'd0);
      check("rst_strobes", 16'({sp_we, pul_we, wrap}), 16'd0);
      rst_n = 1'b1;
      tick();

      // push PC and CC from S=0x1000
      s = 16'h1000; mask = 8'h81; pc = 16'h1234; cc = 8'h5A; use_u = 1'b0; psh_go = 1'b1;
      tick(); psh_go = 1'b0;
      check("p1_busy", 16'(busy), 16'd1);
      check("p1_dec", 16'(psh_dec), 16'd1);
      check("p1_addr0", psh_addr, 16'h1000);
      check("p1_mux0", 16'(psh_mux), 16'h34);
      tick();
      check("p1_addr1", psh_addr, 16'h0FFF);
      check("p1_mux1", 16'(psh_mux), 16'h12);
      tick();
      check("p1_addr2", psh_addr, 16'h0FFE);
      check("p1_mux2", 16'(psh_mux), 16'h5A);
      check("p1_busy2", 16'(busy), 16'd1);
      tick();
      check("p1_busy_end", 16'(busy), 16'd0);
      check("p1_spwe", 16'(sp_we), 16'd1);
      check("p1_spnxt", sp_nxt, 16'h0FFD);
      tick();
      check("p1_spwe_off", 16'(sp_we), 16'd0);

      // pull them back from S=0x0FFD
      s = 16'h0FFD; pul_go = 1'b1;
      tick(); pul_go = 1'b0;
      check("l1_sbusy", 16'(stack_busy), 16'd1);
      check("l1_addr0", psh_addr, 16'h0FFD);
      tick();
      check("l1_addr1", psh_addr, 16'h0FFE);
      check("l1_we_early", 16'(pul_we), 16'd0);
      tick();
      check("l1_we_cc", 16'(pul_we), 16'd1);
      check("l1_sel_cc", 16'(pul_sel), 16'd0);
      check("l1_data_cc", pul_data, 16'h005A);
      check("l1_addr2", psh_addr, 16'h0FFF);
      tick();
      check("l1_drain", 16'({busy, stack_busy, pul_we}), 16'b100);
      tick();
      check("l1_we_pc", 16'(pul_we), 16'd1);
      check("l1_sel_pc", 16'(pul_sel), 16'd7);
      check("l1_data_pc", pul_data, 16'h1234);
      check("l1_spwe", 16'(sp_we), 16'd1);
      check("l1_spnxt", sp_nxt, 16'h1000);
      check("l1_busy_end", 16'(busy), 16'd0);

      // full mask push on U=0x2000, S goes out as the other SP
      use_u = 1'b1; u = 16'h2000; s = 16'hBEEF; mask = 8'hFF;
      y = 16'h5566; x = 16'h7788; dp = 8'h99; b = 8'hBB; a = 8'hAA; psh_go = 1'b1;
      tick(); psh_go = 1'b0;
      for (int i = 0; i < 12; i++) begin
         check("pf_dec", 16'(psh_dec), 16'd1);
         check("pf_addr", psh_addr, 16'h2000 - 16'(i));
         check("pf_mux", 16'(psh_mux), 16'(fb[i]));
         tick();
      end
      check("pf_dec_end", 16'(psh_dec), 16'd0);
      check("pf_spwe", 16'(sp_we), 16'd1);
      check("pf_spnxt", sp_nxt, 16'h1FF4);

      // full mask pull from U=0x1FF4
      u = 16'h1FF4; pul_go = 1'b1;
      tick(); pul_go = 1'b0;
      k = 0; done = 1'b0;
      for (int t = 0; t < 30 && !done; t++) begin
         if (pul_we && k < 8) begin
            check("lf_sel", 16'(pul_sel), 16'(k));
            check("lf_data", pul_data, pd[k]);
            k++;
         end
         if (sp_we) begin
            check("lf_spnxt", sp_nxt, 16'h2000);
            done = 1'b1;
         end
         if (!done) tick();
      end
      check("lf_done", 16'(done), 16'd1);
      check("lf_count", 16'(k), 16'd8);

      // empty mask: nothing starts
      tick();
      mask = 8'h00; psh_go = 1'b1;
      tick(); psh_go = 1'b0;
      check("m0_push", 16'({busy, psh_dec}), 16'd0);
      pul_go = 1'b1;
      tick(); pul_go = 1'b0;
      check("m0_pull", 16'({busy, stack_busy}), 16'd0);
      tick();
      check("m0_strobes", 16'({sp_we, pul_we}), 16'd0);

      // both go bits: push wins
      use_u = 1'b0; s = 16'h0001; mask = 8'h02; a = 8'hA5; psh_go = 1'b1; pul_go = 1'b1;
      tick(); psh_go = 1'b0; pul_go = 1'b0;
      check("bg_dec", 16'({psh_dec, stack_busy}), 16'b10);
      check("bg_addr", psh_addr, 16'h0001);
      check("bg_mux", 16'(psh_mux), 16'hA5);
      tick();
      check("bg_spnxt", sp_nxt, 16'h0000);
      check("bg_wrap", 16'(wrap), 16'd0);

      // push across 0x0000
      s = 16'h0000; mask = 8'h06; b = 8'hB6; a = 8'hA6; psh_go = 1'b1;
      tick(); psh_go = 1'b0;
      check("wr_addr0", psh_addr, 16'h0000);
      check("wr_mux0", 16'(psh_mux), 16'hB6);
      tick();
      check("wr_addr1", psh_addr, 16'hFFFF);
      check("wr_mux1", 16'(psh_mux), 16'hA6);
      tick();
      check("wr_spnxt", sp_nxt, 16'hFFFE);
      check("wr_wrap", 16'(wrap), EXP_WRAP);

      // pull with a go while busy and a cen stall
      s = 16'h0FFD; mask = 8'h81; pul_go = 1'b1;
      tick(); pul_go = 1'b0;
      check("st_wrap_clr", 16'(wrap), 16'd0);
      check("st_addr0", psh_addr, 16'h0FFD);
      psh_go = 1'b1;
      tick();
      check("st_ignore", 16'({psh_dec, stack_busy}), 16'b01);
      check("st_addr1", psh_addr, 16'h0FFE);
      psh_go = 1'b0;
      tick();
      check("st_we_cc", 16'(pul_we), 16'd1);
      cen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("st_frz_we", 16'({pul_we, stack_busy, busy}), 16'b111);
         check("st_frz_addr", psh_addr, 16'h0FFF);
      end
      cen = 1'b1;
      tick();
      check("st_drain", 16'({busy, stack_busy, pul_we}), 16'b100);
      tick();
      check("st_sel_pc", 16'(pul_sel), 16'd7);
      check("st_data_pc", pul_data, 16'h1234);
      check("st_spnxt", sp_nxt, 16'h1000);

      // reset in the middle of a full push
      s = 16'h5000; u = 16'hC3D4; mask = 8'hFF; psh_go = 1'b1;
      tick(); psh_go = 1'b0;
      tick(); tick();
      check("rs_addr3", psh_addr, 16'h4FFE);
      check("rs_mux3", 16'(psh_mux), 16'hD4);
      rst_n = 1'b0;
      #1;
      check("rs_async", 16'({busy, psh_dec, stack_busy, sp_we, pul_we, wrap}), 16'd0);
      check("rs_addr", psh_addr, 16'd0);
      check("rs_mux", 16'(psh_mux), 16'd0);
      tick(); tick();
      check("rs_hold", 16'({busy, sp_we}), 16'd0);
      rst_n = 1'b1;
      s = 16'h3000; mask = 8'h01; cc = 8'h3C; psh_go = 1'b1;
      tick(); psh_go = 1'b0;
      check("rs_new_dec", 16'(psh_dec), 16'd1);
      check("rs_new_addr", psh_addr, 16'h3000);
      check("rs_new_mux", 16'(psh_mux), 16'h3C);
      tick();
      check("rs_new_spwe", 16'(sp_we), 16'd1);
      check("rs_new_spnxt", sp_nxt, 16'h2FFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
